// File: rtl/tff_pkg.sv
// Shared definitions for the T flip-flop based up/down counter.
package tff_pkg;

  // Operating modes selected by the 2-bit mode input.
  typedef enum logic [1:0] {
    TFF_HOLD   = 2'b00,
    TFF_UP     = 2'b01,
    TFF_DOWN   = 2'b10,
    TFF_TOGGLE = 2'b11
  } tff_mode_e;

  // Widest counter the all-ones helper can describe.
  localparam int TFF_MAX_WIDTH = 64;

  // All-ones pattern in the low w bits, zero above; intended for constant use.
  function automatic logic [TFF_MAX_WIDTH-1:0] tffAllOnes(input int w);
    logic [TFF_MAX_WIDTH-1:0] m;
    m = '0;
    for (int i = 0; i < TFF_MAX_WIDTH; i++) begin
      if (i < w) m[i] = 1'b1;
    end
    return m;
  endfunction

endpackage

// File: rtl/t_ff_cell.sv
// Single T flip-flop: toggles on a rising edge when t is high.
module t_ff_cell #(
  parameter logic RESET_BIT = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic t,
  output logic q,
  output logic qbar
);

  logic q_q;
  logic q_d;

  // Next state is the current bit flipped whenever t is asserted.
  always_comb begin
    q_d = q_q ^ t;
  end

  // Cell storage with asynchronous active-low reset to the configured bit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) q_q <= RESET_BIT;
    else        q_q <= q_d;
  end

  assign q    = q_q;
  assign qbar = ~q_q;

endmodule

// File: rtl/tff_updown_counter.sv
// WIDTH-bit counter/register built from T cells: hold, up, down, masked
// toggle and parallel load, with optional saturation, terminal count and
// a registered wrap pulse.
module tff_updown_counter
  import tff_pkg::*;
#(
  parameter int               WIDTH     = 4,
  parameter bit               SATURATE  = 1'b0,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic [1:0]       mode,
  input  logic [WIDTH-1:0] t_mask,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] qbar,
  output logic             tc,
  output logic             wrap
);

  localparam logic [WIDTH-1:0] ALL_ONES = WIDTH'(tffAllOnes(WIDTH));

  tff_mode_e        modeE;
  logic [WIDTH-1:0] tVec;
  logic [WIDTH-1:0] upToggle;
  logic [WIDTH-1:0] downToggle;
  logic             qAllOnes;
  logic             qZero;
  logic             wrap_q;
  logic             wrap_d;

  assign modeE    = tff_mode_e'(mode);
  assign qAllOnes = (q == ALL_ONES);
  assign qZero    = (q == '0);

  // Ripple toggle chains: a bit flips counting up when all lower bits are
  // one, and counting down when all lower bits are zero.
  always_comb begin
    logic upRun;
    logic downRun;
    upToggle   = '0;
    downToggle = '0;
    upRun      = 1'b1;
    downRun    = 1'b1;
    for (int i = 0; i < WIDTH; i++) begin
      upToggle[i]   = upRun;
      downToggle[i] = downRun;
      upRun         = upRun & q[i];
      downRun       = downRun & ~q[i];
    end
  end

  // Toggle vector selection by priority: load, then enable/mode; saturation
  // suppresses the step at the top or bottom of the range.
  always_comb begin
    tVec = '0;
    if (load) begin
      tVec = q ^ load_val;
    end else if (en) begin
      case (modeE)
        TFF_HOLD:   tVec = '0;
        TFF_UP:     tVec = (SATURATE && qAllOnes) ? '0 : upToggle;
        TFF_DOWN:   tVec = (SATURATE && qZero) ? '0 : downToggle;
        TFF_TOGGLE: tVec = t_mask;
        default:    tVec = '0;
      endcase
    end
  end

  // Terminal count is purely combinational on the current state and controls.
  always_comb begin
    tc = en & ~load & (((modeE == TFF_UP) & qAllOnes) |
                       ((modeE == TFF_DOWN) & qZero));
  end

  // A wrap only really happens when the counter is not saturating.
  always_comb begin
    wrap_d = tc & ~SATURATE;
  end

  // One-cycle wrap pulse register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) wrap_q <= 1'b0;
    else        wrap_q <= wrap_d;
  end

  assign wrap = wrap_q;

  for (genvar i = 0; i < WIDTH; i++) begin : g_cell
    t_ff_cell #(
      .RESET_BIT (RESET_VAL[i])
    ) u_cell (
      .clk  (clk),
      .rst_n(rst_n),
      .t    (tVec[i]),
      .q    (q[i]),
      .qbar (qbar[i])
    );
  end

endmodule

// File: tb/tb_tff_updown_counter.sv
// Directed self-checking bench: three counter configurations share one
// stimulus stream (plain wrapping, saturating, and non-zero reset value).
module tb_tff_updown_counter;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       en = 1'b0;
  logic [1:0] mode = 2'b00;
  logic [3:0] t_mask = 4'h0;
  logic       load = 1'b0;
  logic [3:0] load_val = 4'h0;

  logic [3:0] qA, qbarA, qS, qbarS, qR, qbarR;
  logic       tcA, wrapA, tcS, wrapS, tcR, wrapR;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  tff_updown_counter #(.WIDTH(4), .SATURATE(1'b0), .RESET_VAL(4'h0)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .mode(mode), .t_mask(t_mask),
    .load(load), .load_val(load_val), .q(qA), .qbar(qbarA), .tc(tcA), .wrap(wrapA));

  tff_updown_counter #(.WIDTH(4), .SATURATE(1'b1), .RESET_VAL(4'h0)) dutSat (
    .clk(clk), .rst_n(rst_n), .en(en), .mode(mode), .t_mask(t_mask),
    .load(load), .load_val(load_val), .q(qS), .qbar(qbarS), .tc(tcS), .wrap(wrapS));

  tff_updown_counter #(.WIDTH(4), .SATURATE(1'b0), .RESET_VAL(4'h5)) dutRst (
    .clk(clk), .rst_n(rst_n), .en(en), .mode(mode), .t_mask(t_mask),
    .load(load), .load_val(load_val), .q(qR), .qbar(qbarR), .tc(tcR), .wrap(wrapR));

  // Advance one rising edge and settle away from it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    #3;
    rst_n = 1'b0;
    #1;
    checks++;
    if (qA !== 4'h0) begin failures++; $display("[TB] FAIL reset_q: got %h expected %h", qA, 4'h0); end
    checks++;
    if (qbarA !== 4'hF) begin failures++; $display("[TB] FAIL reset_qbar: got %h expected %h", qbarA, 4'hF); end
    checks++;
    if (wrapA !== 1'b0) begin failures++; $display("[TB] FAIL reset_wrap: got %b expected 0", wrapA); end
    checks++;
    if (qR !== 4'h5) begin failures++; $display("[TB] FAIL reset_val_q: got %h expected %h", qR, 4'h5); end
    tick();
    rst_n = 1'b1;
    en = 1'b1;
    mode = 2'b00;
    for (int k = 0; k < 3; k++) begin
      tick();
      checks++;
      if (qA !== 4'h0) begin failures++; $display("[TB] FAIL hold_q[%0d]: got %h expected %h", k, qA, 4'h0); end
      checks++;
      if (wrapA !== 1'b0) begin failures++; $display("[TB] FAIL hold_wrap[%0d]: got %b expected 0", k, wrapA); end
    end
  endtask

  task automatic test_up_wrap();
    logic [3:0] expQ;
    logic       expWrap;
    expQ = 4'h0;
    en = 1'b1;
    mode = 2'b01;
    for (int k = 1; k <= 17; k++) begin
      checks++;
      if (tcA !== (expQ == 4'hF)) begin failures++; $display("[TB] FAIL up_tc[%0d]: got %b expected %b", k, tcA, (expQ == 4'hF)); end
      expWrap = (expQ == 4'hF);
      tick();
      expQ = expQ + 4'h1;
      checks++;
      if (qA !== expQ) begin failures++; $display("[TB] FAIL up_q[%0d]: got %h expected %h", k, qA, expQ); end
      checks++;
      if (wrapA !== expWrap) begin failures++; $display("[TB] FAIL up_wrap[%0d]: got %b expected %b", k, wrapA, expWrap); end
      checks++;
      if (wrapS !== 1'b0) begin failures++; $display("[TB] FAIL sat_up_wrap[%0d]: got %b expected 0", k, wrapS); end
    end
    checks++;
    if (qS !== 4'hF) begin failures++; $display("[TB] FAIL sat_up_q: got %h expected %h", qS, 4'hF); end
  endtask

  task automatic test_down_saturate();
    logic [3:0] expQ [4];
    logic       expTc [4];
    expQ  = '{4'h1, 4'h0, 4'h0, 4'h0};
    expTc = '{1'b0, 1'b0, 1'b1, 1'b1};
    load = 1'b1;
    load_val = 4'h2;
    tick();
    load = 1'b0;
    checks++;
    if (qS !== 4'h2) begin failures++; $display("[TB] FAIL sat_load_q: got %h expected %h", qS, 4'h2); end
    mode = 2'b10;
    for (int k = 0; k < 4; k++) begin
      checks++;
      if (tcS !== expTc[k]) begin failures++; $display("[TB] FAIL sat_down_tc[%0d]: got %b expected %b", k, tcS, expTc[k]); end
      tick();
      checks++;
      if (qS !== expQ[k]) begin failures++; $display("[TB] FAIL sat_down_q[%0d]: got %h expected %h", k, qS, expQ[k]); end
      checks++;
      if (wrapS !== 1'b0) begin failures++; $display("[TB] FAIL sat_down_wrap[%0d]: got %b expected 0", k, wrapS); end
      if (k == 2) begin
        checks++;
        if (qA !== 4'hF) begin failures++; $display("[TB] FAIL down_wrap_q: got %h expected %h", qA, 4'hF); end
        checks++;
        if (wrapA !== 1'b1) begin failures++; $display("[TB] FAIL down_wrap_pulse: got %b expected 1", wrapA); end
      end
      if (k == 3) begin
        checks++;
        if (qA !== 4'hE) begin failures++; $display("[TB] FAIL down_after_wrap_q: got %h expected %h", qA, 4'hE); end
        checks++;
        if (wrapA !== 1'b0) begin failures++; $display("[TB] FAIL down_wrap_clear: got %b expected 0", wrapA); end
      end
    end
  endtask

  task automatic test_masked_toggle();
    logic [3:0] expQ [2];
    expQ = '{4'b1100, 4'b1010};
    load = 1'b1;
    load_val = 4'b1010;
    tick();
    load = 1'b0;
    mode = 2'b11;
    t_mask = 4'b0110;
    for (int k = 0; k < 2; k++) begin
      checks++;
      if (tcA !== 1'b0) begin failures++; $display("[TB] FAIL toggle_tc[%0d]: got %b expected 0", k, tcA); end
      tick();
      checks++;
      if (qA !== expQ[k]) begin failures++; $display("[TB] FAIL toggle_q[%0d]: got %b expected %b", k, qA, expQ[k]); end
      checks++;
      if (qbarA !== ~expQ[k]) begin failures++; $display("[TB] FAIL toggle_qbar[%0d]: got %b expected %b", k, qbarA, ~expQ[k]); end
    end
    t_mask = 4'h0;
  endtask

  task automatic test_priority_enable();
    load = 1'b1;
    load_val = 4'h9;
    en = 1'b0;
    mode = 2'b01;
    tick();
    checks++;
    if (qA !== 4'h9) begin failures++; $display("[TB] FAIL prio_load_q: got %h expected %h", qA, 4'h9); end
    load = 1'b0;
    for (int k = 0; k < 2; k++) begin
      tick();
      checks++;
      if (qA !== 4'h9) begin failures++; $display("[TB] FAIL en_hold_q[%0d]: got %h expected %h", k, qA, 4'h9); end
    end
    checks++;
    if (tcA !== 1'b0) begin failures++; $display("[TB] FAIL en_off_tc: got %b expected 0", tcA); end
  endtask

  task automatic test_load_priority();
    load = 1'b1;
    load_val = 4'hF;
    en = 1'b1;
    mode = 2'b01;
    tick();
    checks++;
    if (tcA !== 1'b0) begin failures++; $display("[TB] FAIL load_tc: got %b expected 0", tcA); end
    tick();
    checks++;
    if (qA !== 4'hF) begin failures++; $display("[TB] FAIL load_over_up_q: got %h expected %h", qA, 4'hF); end
    checks++;
    if (wrapA !== 1'b0) begin failures++; $display("[TB] FAIL load_over_up_wrap: got %b expected 0", wrapA); end
    load = 1'b0;
  endtask

  task automatic test_reset_mid_count();
    load = 1'b1;
    load_val = 4'hA;
    tick();
    load = 1'b0;
    en = 1'b1;
    mode = 2'b01;
    tick();
    tick();
    checks++;
    if (qR !== 4'hC) begin failures++; $display("[TB] FAIL mid_count_q: got %h expected %h", qR, 4'hC); end
    load = 1'b1;
    load_val = 4'h3;
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (qR !== 4'h5) begin failures++; $display("[TB] FAIL mid_reset_q: got %h expected %h", qR, 4'h5); end
    checks++;
    if (qbarR !== 4'hA) begin failures++; $display("[TB] FAIL mid_reset_qbar: got %h expected %h", qbarR, 4'hA); end
    tick();
    checks++;
    if (qR !== 4'h5) begin failures++; $display("[TB] FAIL reset_over_load_q: got %h expected %h", qR, 4'h5); end
    rst_n = 1'b1;
    load = 1'b0;
    tick();
    checks++;
    if (qR !== 4'h6) begin failures++; $display("[TB] FAIL after_release_q: got %h expected %h", qR, 4'h6); end
  endtask

  initial begin
    $display("[TB] starting tff_updown_counter bench");
    test_reset();
    test_up_wrap();
    test_down_saturate();
    test_masked_toggle();
    test_priority_enable();
    test_load_priority();
    test_reset_mid_count();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
